// File: rtl/sd_img_switch_pkg.sv
// Shared types and helpers for the SD-card image switch.
// Pure declarations: no logic, no latency.
// No flow control of its own; it is imported by the switch and its timer.
package sd_img_pkg;

   // Encoding of the physical card on the sel bus; slot k is encoded as k+1.
   localparam int SEL_PHYS = 0;

   // Widest target encoding the switch supports (physical plus up to 7 slots).
   typedef logic [2:0] sel_t;

   // Width of the sel bus for a given slot count.
   function automatic int sd_selw(input int num_img);
      return (num_img < 1) ? 1 : $clog2(num_img + 1);
   endfunction

endpackage

// File: rtl/sd_hold_timer.sv
// Retriggerable hold timer: active for HOLD cycles after the last load pulse.
// Latency: load at cycle t raises active_o at t+1 and it drops after t+HOLD.
// No backpressure; a load while active simply restarts the hold.
module sd_hold_timer #(
   parameter int HOLD = 16
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic load_i,
   output logic active_o
);

   localparam int CW = $clog2(HOLD + 1);

   // Remaining hold cycles. Zero out of reset, so active_o starts low; this is
   // the mirror of an up-counter that resets to, and saturates at, HOLD.
   logic [CW-1:0] cnt_q, cnt_d;

   // Reload on every load pulse, otherwise count down and stick at zero.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = CW'(HOLD);
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   // Counter register.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign active_o = (cnt_q != '0);

endmodule

// File: rtl/sd_img_switch.sv
// Routes the core SPI SD master to the physical card or one of NUM_IMG image slots.
// Latency: mount pulse at t updates mounted/pend_sel/sel at t+1; routing is combinational.
// No backpressure; SD_IMG_SWITCH_DEFER_EN holds target changes until spi_ss is high.
module sd_img_switch
   import sd_img_pkg::*;
#(
   parameter int NUM_IMG     = 2,
   parameter int ACT_TIMEOUT = 1000000,
   parameter int RST_HOLD    = 10000000,
   localparam int SELW       = sd_selw(NUM_IMG)
) (
   input  logic               clk_sys,
   input  logic               reset_n,
   input  logic [NUM_IMG-1:0] img_mounted,
   input  logic [63:0]        img_size,
   input  logic               spi_ss,
   input  logic               spi_sck,
   input  logic               spi_mosi,
   output logic               spi_miso,
   output logic [NUM_IMG-1:0] vsd_ss,
   input  logic [NUM_IMG-1:0] vsd_miso,
   output logic               SD_CS,
   output logic               SD_SCK,
   output logic               SD_MOSI,
   input  logic               SD_MISO,
   output logic [SELW-1:0]    sel,
   output logic               reset_req,
   output logic               act_phys,
   output logic               act_virt
);

   logic [NUM_IMG-1:0] mounted_q, mounted_d;
   logic [SELW-1:0]    pend_q, pend_d;
   logic [SELW-1:0]    sel_q, sel_d;
   logic [SELW-1:0]    hi_sel;
   logic               any_pulse;
   int                 lo_idx;
   logic               miso_mux;
   logic               mosi_q, miso_q;
   logic               act_load, act;

   // Mount bookkeeping and target choice. The lowest pulsing slot decides the
   // target; the unmount check uses pend_q so a slot that is waiting to be
   // switched to is also retargeted if it disappears first.
   always_comb begin
      mounted_d = mounted_q;
      pend_d    = pend_q;
      any_pulse = 1'b0;
      lo_idx    = 0;
      hi_sel    = SELW'(SEL_PHYS);
      for (int k = NUM_IMG - 1; k >= 0; k--) begin
         if (img_mounted[k]) begin
            mounted_d[k] = (img_size != 64'd0);
            any_pulse    = 1'b1;
            lo_idx       = k;
         end
      end
      for (int k = 0; k < NUM_IMG; k++) begin
         if (mounted_d[k]) hi_sel = SELW'(k + 1);
      end
      if (any_pulse) begin
         if (img_size != 64'd0) begin
            pend_d = SELW'(lo_idx + 1);
         end else if (pend_q == SELW'(lo_idx + 1)) begin
            pend_d = hi_sel;
         end
      end
   end

`ifdef SD_IMG_SWITCH_DEFER_EN
   // Only switch while the core is deselected, never mid-transaction.
   assign sel_d = spi_ss ? pend_d : sel_q;
`else
   assign sel_d = pend_d;
`endif

   // State registers, including the prior values used for edge detection.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         mounted_q <= '0;
         pend_q    <= SELW'(SEL_PHYS);
         sel_q     <= SELW'(SEL_PHYS);
         mosi_q    <= 1'b0;
         miso_q    <= 1'b0;
      end else begin
         mounted_q <= mounted_d;
         pend_q    <= pend_d;
         sel_q     <= sel_d;
         mosi_q    <= spi_mosi;
         miso_q    <= miso_mux;
      end
   end

   // Per-slot chip selects and the MISO return path for the active target.
   always_comb begin
      vsd_ss   = '1;
      miso_mux = SD_MISO;
      for (int k = 0; k < NUM_IMG; k++) begin
         vsd_ss[k] = (sel_q != SELW'(k + 1)) | spi_ss;
         if (sel_q == SELW'(k + 1)) miso_mux = vsd_miso[k];
      end
   end

   assign SD_CS    = (sel_q != SELW'(SEL_PHYS)) | spi_ss;
   assign SD_SCK   = spi_sck & ~SD_CS;
   assign SD_MOSI  = spi_mosi & ~SD_CS;
   assign spi_miso = miso_mux;
   assign sel      = sel_q;

   assign act_load = (spi_mosi ^ mosi_q) | (miso_mux ^ miso_q);

   sd_hold_timer #(.HOLD(RST_HOLD)) u_rst_timer (
      .clk_i    (clk_sys),
      .rst_n_i  (reset_n),
      .load_i   (|img_mounted),
      .active_o (reset_req)
   );

   sd_hold_timer #(.HOLD(ACT_TIMEOUT)) u_act_timer (
      .clk_i    (clk_sys),
      .rst_n_i  (reset_n),
      .load_i   (act_load),
      .active_o (act)
   );

   assign act_phys = act & (sel_q == SELW'(SEL_PHYS));
   assign act_virt = act & (sel_q != SELW'(SEL_PHYS));

endmodule

// File: tb/tb_sd_img_switch.sv
// Directed bench for sd_img_switch with 3 slots, 16-cycle activity hold, 32-cycle reset hold.
// Inputs change 1 time unit after the rising edge; outputs are checked at the same point.
// Expectations follow SD_IMG_SWITCH_DEFER_EN when it is defined for the build.
module tb_sd_img_switch;

   logic        clk_sys = 1'b0;
   logic        reset_n = 1'b0;
   logic [2:0]  img_mounted;
   logic [63:0] img_size;
   logic        spi_ss, spi_sck, spi_mosi, spi_miso;
   logic [2:0]  vsd_ss, vsd_miso;
   logic        SD_CS, SD_SCK, SD_MOSI, SD_MISO;
   logic [1:0]  sel;
   logic        reset_req, act_phys, act_virt;

   int tests = 0;
   int fails = 0;
   int n;

   sd_img_switch #(
      .NUM_IMG     (3),
      .ACT_TIMEOUT (16),
      .RST_HOLD    (32)
   ) dut (
      .clk_sys     (clk_sys),
      .reset_n     (reset_n),
      .img_mounted (img_mounted),
      .img_size    (img_size),
      .spi_ss      (spi_ss),
      .spi_sck     (spi_sck),
      .spi_mosi    (spi_mosi),
      .spi_miso    (spi_miso),
      .vsd_ss      (vsd_ss),
      .vsd_miso    (vsd_miso),
      .SD_CS       (SD_CS),
      .SD_SCK      (SD_SCK),
      .SD_MOSI     (SD_MOSI),
      .SD_MISO     (SD_MISO),
      .sel         (sel),
      .reset_req   (reset_req),
      .act_phys    (act_phys),
      .act_virt    (act_virt)
   );

   always #5 clk_sys = ~clk_sys;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic pulse(input logic [2:0] slots, input logic [63:0] size);
      img_mounted = slots;
      img_size    = size;
      tick();
      img_mounted = 3'b000;
   endtask

   initial begin
      img_mounted = 3'b000;
      img_size    = 64'd0;
      spi_ss      = 1'b1;
      spi_sck     = 1'b0;
      spi_mosi    = 1'b0;
      vsd_miso    = 3'b000;
      SD_MISO     = 1'b0;

      // 1. reset state
      repeat (3) tick();
      chk("rst_sel", sel, 2'd0);
      chk("rst_reset_req", reset_req, 1'b0);
      chk("rst_act_phys", act_phys, 1'b0);
      chk("rst_act_virt", act_virt, 1'b0);
      chk("rst_vsd_ss", vsd_ss, 3'b111);
      chk("rst_sd_cs", SD_CS, 1'b1);
      reset_n = 1'b1;
      repeat (2) tick();
      chk("idle_act_phys", act_phys, 1'b0);

      // 2. mount slot 1 while deselected
      pulse(3'b010, 64'd512);
      chk("m1_sel", sel, 2'd2);
      chk("m1_reset_req_rise", reset_req, 1'b1);
      vsd_miso = 3'b010;
      #1 chk("m1_miso_hi", spi_miso, 1'b1);
      vsd_miso = 3'b101;
      #1 chk("m1_miso_lo", spi_miso, 1'b0);
      vsd_miso = 3'b000;
      spi_ss = 1'b0;
      #1 chk("m1_vsd_ss", vsd_ss, 3'b101);
      chk("m1_sd_cs", SD_CS, 1'b1);
      spi_ss = 1'b1;
      n = 1;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (reset_req) n++;
      end
      chk("m1_reset_req_len", n, 32);
      chk("m1_reset_req_fall", reset_req, 1'b0);

      // 3. mount slot 2 inside a transaction
      spi_ss = 1'b0;
      pulse(3'b100, 64'd1024);
`ifdef SD_IMG_SWITCH_DEFER_EN
      chk("m2_sel_held", sel, 2'd2);
      repeat (3) tick();
      chk("m2_sel_still_held", sel, 2'd2);
      chk("m2_old_target_routed", vsd_ss, 3'b101);
      spi_ss = 1'b1;
      tick();
      chk("m2_sel_switched", sel, 2'd3);
`else
      chk("m2_sel_immediate", sel, 2'd3);
      spi_ss = 1'b1;
      tick();
`endif

      // 4. simultaneous mounts: lowest slot wins
      pulse(3'b101, 64'd2048);
      chk("m02_sel", sel, 2'd1);
      chk("m02_mounted", dut.mounted_q, 3'b111);

      // 5. unmounts
      pulse(3'b001, 64'd0);
      chk("u0_sel", sel, 2'd3);
      chk("u0_mounted", dut.mounted_q, 3'b110);
      pulse(3'b100, 64'd0);
      chk("u2_sel", sel, 2'd2);
      pulse(3'b010, 64'd0);
      chk("u1_sel", sel, 2'd0);
      chk("u1_mounted", dut.mounted_q, 3'b000);
      spi_ss  = 1'b0;
      spi_sck = 1'b1;
      #1 chk("phys_sck_hi", SD_SCK, 1'b1);
      chk("phys_cs", SD_CS, 1'b0);
      chk("phys_vsd_ss", vsd_ss, 3'b111);
      spi_sck = 1'b0;
      #1 chk("phys_sck_lo", SD_SCK, 1'b0);
      spi_ss  = 1'b1;
      spi_sck = 1'b1;
      #1 chk("phys_sck_gated", SD_SCK, 1'b0);
      spi_sck = 1'b0;
      chk("pre_act_phys", act_phys, 1'b0);
      chk("pre_act_virt", act_virt, 1'b0);

      // 6. activity LED: single edge, then retrigger
      spi_mosi = 1'b1;
      tick();
      chk("act_rise", act_phys, 1'b1);
      n = 1;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (act_phys) n++;
      end
      chk("act_len", n, 16);
      chk("act_fall", act_phys, 1'b0);
      spi_mosi = 1'b0;
      tick();
      chk("act2_rise", act_phys, 1'b1);
      repeat (8) tick();
      spi_mosi = 1'b1;
      tick();
      n = 1;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (act_phys) n++;
         if (i == 6) chk("act2_past_first_hold", act_phys, 1'b1);
      end
      chk("act2_retrig_len", n, 16);
      chk("act2_virt_off", act_virt, 1'b0);

      // asynchronous reset mid-operation
      pulse(3'b001, 64'd512);
      chk("ar_sel_before", sel, 2'd1);
      #2 reset_n = 1'b0;
      #1 chk("ar_sel", sel, 2'd0);
      chk("ar_reset_req", reset_req, 1'b0);
      chk("ar_mounted", dut.mounted_q, 3'b000);
      reset_n = 1'b1;
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/sd_img_switch.md
# sd_img_switch

Parametrised SD-card routing block in the MiSTer core top level. It sits between the core's SPI SD master and two kinds of target: the physical SD card and NUM_IMG virtual-image `sd_card` instances. It tracks which images are mounted and picks the active target. It generates the post-mount cold-reset request and drives per-target-class activity LEDs.

## Interface
Parameters:
- NUM_IMG, 2: number of virtual-image slots, 1..7.
- ACT_TIMEOUT, 1000000: activity LED hold, in clk_sys cycles.
- RST_HOLD, 10000000: reset_req hold after a mount event, in cycles.

Ports:
- Clocking and reset: one clock, clk_sys; reset is asynchronous and active-low, reset_n. These are fixed.
- clk_sys  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- img_mounted  in  NUM_IMG  one-cycle mount pulse per slot.
- img_size  in  64  size of the image being mounted; valid with its pulse.
- spi_ss  in  1  core chip select, active-low.
- spi_sck, spi_mosi  in  1 each  core SPI clock and data.
- spi_miso  out  1  MISO returned to the core.
- vsd_ss  out  NUM_IMG  per-slot chip select, active-low.
- vsd_miso  in  NUM_IMG  per-slot MISO.
- SD_CS, SD_SCK, SD_MOSI  out  1 each  physical card.
- SD_MISO  in  1  physical card.
- sel  out  SELW  active target: 0 = physical, k = slot k-1.
- reset_req  out  1  cold-reset request.
- act_phys, act_virt  out  1 each  activity LEDs.

## Operation
- mounted[NUM_IMG] register:
  - A pulse with img_size != 0 sets the slot's bit.
  - A pulse with img_size == 0 (unmount) clears it.
- Target choice (pend_sel):
  - Mount of slot k: pend_sel = k+1.
  - Unmount of the currently selected slot: pend_sel = highest-index slot still mounted, else 0.
  - Unmount of a non-selected slot: pend_sel unchanged.
  - Simultaneous pulses: the lowest index wins; all mounted bits still update.
- sel loads pend_sel (see Configuration).
- Routing (combinational from sel):
  - SD_CS = (sel!=0) | spi_ss.
  - SD_SCK = spi_sck & ~SD_CS; SD_MOSI = spi_mosi & ~SD_CS.
  - vsd_ss[k] = (sel!=k+1) | spi_ss.
  - spi_miso = SD_MISO when sel==0, else vsd_miso[sel-1].
- reset_req:
  - Any mount or unmount pulse asserts it and loads the hold counter with RST_HOLD.
  - A new pulse while it is asserted reloads the counter (retrigger).
- Activity timer:
  - Counter saturates at ACT_TIMEOUT.
  - Cleared on any edge of spi_mosi or the selected MISO.
  - act = counter < ACT_TIMEOUT.
  - act_phys = act & (sel==0); act_virt = act & (sel!=0).
- Reset values:
  - mounted 0, sel 0, pend_sel 0.
  - reset_req 0.
  - activity counter = ACT_TIMEOUT, so both LEDs are off.
  - SD_CS follows spi_ss; all vsd_ss 1.

## Timing
- Mount pulse at cycle t:
  - mounted and pend_sel update at t+1.
  - reset_req is high from t+1 through t+RST_HOLD inclusive, then low.
- Edge detection: prior values are registered. An input change sampled at t raises act at t+1. act stays high for ACT_TIMEOUT cycles after the last edge.
- Arithmetic widths:
  - SELW = $clog2(NUM_IMG+1).
  - Counters are $clog2(max+1) bits and never wrap.
- reset_n asserted mid-operation: all state returns to its reset value immediately. Pending switches are dropped.

## Configuration
- SD_IMG_SWITCH_DEFER_EN defined:
  - sel loads pend_sel only on a cycle where spi_ss==1, so no target change happens inside an SPI transaction.
  - While a change is waiting, the old target stays routed.
- Undefined: sel loads pend_sel at t+1 unconditionally.

## Structure
- Package sd_img_pkg holds:
  - the SELW width function;
  - the SEL_PHYS = 0 constant;
  - the sel_t typedef.
- One sub-module, sd_hold_timer: a retriggerable saturating down-counter parametrised by HOLD. It has a load input and an active output.
  - Instantiated twice: once for reset_req and once for the activity LEDs.

## Test plan
Bench configuration: NUM_IMG=3, ACT_TIMEOUT=16, RST_HOLD=32, DEFER enabled.

1. After reset: sel=0, reset_req=0, act_phys=0, act_virt=0, vsd_ss=3'b111.
2. Mount slot 1 (img_size=512) with spi_ss=1 -> sel=2 at t+1; reset_req high for exactly 32 cycles; spi_miso tracks vsd_miso[1].
3. Mount slot 2 while spi_ss=0 -> sel holds 2 until spi_ss rises, then becomes 3 on the next cycle.
4. Mount slots 0 and 2 in the same cycle -> sel=1, mounted=3'b111.
5. Unmount the selected slot 0 with slots 1 and 2 mounted -> sel=3. Then unmount slots 2 and 1 -> sel=0, and SD_SCK follows spi_sck.
6. Toggle spi_mosi once with sel=0 -> act_phys high for 16 cycles, then low. A second pulse at cycle 10 of the hold reloads the counter (retrigger), so act_phys stays high until 16 cycles after that pulse.
